// File: rtl/ag_tcu_uop_seq_pkg.sv
// Shared types, geometry and helpers for the AG-TCU micro-op sequencer.
// Geometry is 4x4x4 steps; the uop struct uses the package default field widths.
package ag_tcu_uop_seq_pkg;

  localparam int AG_TCU_M_STEPS      = 4;
  localparam int AG_TCU_N_STEPS      = 4;
  localparam int AG_TCU_K_STEPS      = 4;
  localparam int AG_TCU_UOPS         = AG_TCU_M_STEPS * AG_TCU_N_STEPS * AG_TCU_K_STEPS;
  localparam int AG_TCU_MAX_STEPS_MN = (AG_TCU_M_STEPS > AG_TCU_N_STEPS) ? AG_TCU_M_STEPS : AG_TCU_N_STEPS;
  localparam int AG_TCU_MAX_STEPS    = (AG_TCU_MAX_STEPS_MN > AG_TCU_K_STEPS) ? AG_TCU_MAX_STEPS_MN : AG_TCU_K_STEPS;
  localparam int AG_TCU_STEP_BITS    = $clog2(AG_TCU_MAX_STEPS);
  localparam int AG_TCU_UOP_BITS     = $clog2(AG_TCU_UOPS);

  localparam int AG_TCU_B_SUB_BLOCKS = 2;
  localparam int AG_TCU_RA           = 0;
  localparam int AG_TCU_RB           = 10;
  localparam int AG_TCU_RC           = 24;

  localparam int AG_TCU_WID_W        = 4;
  localparam int AG_TCU_TAG_W        = 8;
  localparam int AG_TCU_REG_W        = 6;

  localparam logic [3:0] AG_TCU_I32_ID = 4'd8;
  localparam logic [3:0] AG_TCU_I8_ID  = 4'd9;
  localparam logic [3:0] AG_TCU_U8_ID  = 4'd10;
  localparam logic [3:0] AG_TCU_I4_ID  = 4'd11;
  localparam logic [3:0] AG_TCU_U4_ID  = 4'd12;

  typedef logic [AG_TCU_STEP_BITS-1:0] step_t;

  typedef enum logic {SEQ_IDLE, SEQ_ISSUE} seq_state_e;

  typedef struct packed {
    logic [AG_TCU_WID_W-1:0] wid;
    logic [AG_TCU_TAG_W-1:0] tag;
    logic [3:0]              fmt_s;
    logic [3:0]              fmt_d;
    step_t                   step_m;
    step_t                   step_n;
    step_t                   step_k;
    logic [AG_TCU_REG_W-1:0] rs1;
    logic [AG_TCU_REG_W-1:0] rs2;
    logic [AG_TCU_REG_W-1:0] rs3;
    logic                    last;
  } ag_tcu_uop_t;

  function automatic logic fmt_legal(input logic [3:0] fmt_s, input logic [3:0] fmt_d);
    return (fmt_d == AG_TCU_I32_ID) && (fmt_s >= AG_TCU_I8_ID) && (fmt_s <= AG_TCU_U4_ID);
  endfunction

  // Register indices wrap modulo 2^REG_W through the size casts.
  function automatic ag_tcu_uop_t make_uop(
    input logic [AG_TCU_WID_W-1:0] wid,
    input logic [AG_TCU_TAG_W-1:0] tag,
    input logic [3:0]              fmt_s,
    input logic [3:0]              fmt_d,
    input step_t                   m,
    input step_t                   n,
    input step_t                   k
  );
    ag_tcu_uop_t u;
    int idx;
    idx      = (int'(k) * AG_TCU_M_STEPS + int'(m)) * AG_TCU_N_STEPS + int'(n);
    u.wid    = wid;
    u.tag    = tag;
    u.fmt_s  = fmt_s;
    u.fmt_d  = fmt_d;
    u.step_m = m;
    u.step_n = n;
    u.step_k = k;
    u.rs1    = AG_TCU_REG_W'(AG_TCU_RA + int'(m) * AG_TCU_K_STEPS + int'(k));
    u.rs2    = AG_TCU_REG_W'(AG_TCU_RB + (int'(n) * AG_TCU_K_STEPS + int'(k)) / AG_TCU_B_SUB_BLOCKS);
    u.rs3    = AG_TCU_REG_W'(AG_TCU_RC + int'(m) * AG_TCU_N_STEPS + int'(n));
    u.last   = (idx == AG_TCU_UOPS - 1);
    return u;
  endfunction

endpackage

// File: rtl/ag_tcu_step_counter.sv
// Nested step counter: n innermost, then m, k outermost. Exposes the successor
// of the current step and whether the current step is the final one.
module ag_tcu_step_counter
  import ag_tcu_uop_seq_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  inc,
  input  logic  clear,
  output step_t nxt_m,
  output step_t nxt_n,
  output step_t nxt_k,
  output logic  last
);

  localparam step_t M_MAX = step_t'(AG_TCU_M_STEPS - 1);
  localparam step_t N_MAX = step_t'(AG_TCU_N_STEPS - 1);
  localparam step_t K_MAX = step_t'(AG_TCU_K_STEPS - 1);

  step_t m_q, n_q, k_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_m = m_q;
    nxt_n = n_q;
    nxt_k = k_q;
    if (n_q == N_MAX) begin
      nxt_n = '0;
      if (m_q == M_MAX) begin
        nxt_m = '0;
        nxt_k = (k_q == K_MAX) ? '0 : k_q + step_t'(1);
      end else begin
        nxt_m = m_q + step_t'(1);
      end
    end else begin
      nxt_n = n_q + step_t'(1);
    end
  end

  assign last = (m_q == M_MAX) && (n_q == N_MAX) && (k_q == K_MAX);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else if (clear) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else if (inc) begin
      m_q <= nxt_m;
      n_q <= nxt_n;
      k_q <= nxt_k;
    end
  end

endmodule

// File: rtl/ag_tcu_uop_seq.sv
// Expands one WMMA request into AG_TCU_UOPS registered micro-ops, issued in order.
// Optional AG_TCU_SEQ_PERF_EN adds perf_wmma / perf_stall counters.
module ag_tcu_uop_seq
  import ag_tcu_uop_seq_pkg::*;
#(
  parameter int WID_W = AG_TCU_WID_W,
  parameter int TAG_W = AG_TCU_TAG_W,
  parameter int REG_W = AG_TCU_REG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WID_W-1:0] in_wid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [3:0]       in_fmt_s,
  input  logic [3:0]       in_fmt_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WID_W-1:0] out_wid,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_fmt_s,
  output logic [3:0]       out_fmt_d,
  output logic [1:0]       out_step_m,
  output logic [1:0]       out_step_n,
  output logic [1:0]       out_step_k,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic [REG_W-1:0] out_rs3,
  output logic             out_last,
  output logic             err_fmt
`ifdef AG_TCU_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_wmma,
  output logic [31:0]      perf_stall
`endif
);

  seq_state_e  state_q, state_d;
  ag_tcu_uop_t uop_q;
  step_t       nxt_m, nxt_n, nxt_k;
  logic        legal, accept, hs, cnt_last;

  assign legal     = fmt_legal(in_fmt_s, in_fmt_d);
  assign out_valid = (state_q == SEQ_ISSUE);
  assign hs        = out_valid && out_ready;
  assign in_ready  = (state_q == SEQ_IDLE) || (hs && cnt_last);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (accept)             state_d = legal ? SEQ_ISSUE : SEQ_IDLE;
    else if (hs && cnt_last) state_d = SEQ_IDLE;
  end

  ag_tcu_step_counter u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hs && !cnt_last),
    .clear   (accept && legal),
    .nxt_m   (nxt_m),
    .nxt_n   (nxt_n),
    .nxt_k   (nxt_k),
    .last    (cnt_last)
  );

  // The uop register holds the presented uop; it is preloaded with uop0 on accept
  // and with the successor on each non-final handshake, so stalls hold it stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
      // NOTE: the output register is reset because its fields are visible outputs with a defined reset value.
      uop_q   <= '0;
      err_fmt <= 1'b0;
    end else begin
      state_q <= state_d;
      err_fmt <= accept && !legal;
      if (accept && legal)
        uop_q <= make_uop(in_wid, in_tag, in_fmt_s, in_fmt_d, '0, '0, '0);
      else if (hs && !cnt_last)
        uop_q <= make_uop(uop_q.wid, uop_q.tag, uop_q.fmt_s, uop_q.fmt_d, nxt_m, nxt_n, nxt_k);
    end
  end

  assign out_wid    = uop_q.wid;
  assign out_tag    = uop_q.tag;
  assign out_fmt_s  = uop_q.fmt_s;
  assign out_fmt_d  = uop_q.fmt_d;
  assign out_step_m = uop_q.step_m;
  assign out_step_n = uop_q.step_n;
  assign out_step_k = uop_q.step_k;
  assign out_rs1    = uop_q.rs1;
  assign out_rs2    = uop_q.rs2;
  assign out_rs3    = uop_q.rs3;
  assign out_last   = uop_q.last;

`ifdef AG_TCU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_wmma  <= '0;
      perf_stall <= '0;
    end else begin
      if (accept && legal)         perf_wmma  <= perf_wmma + 32'd1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ag_tcu_uop_seq.sv
// Self-checking bench for ag_tcu_uop_seq: a queue-based uop model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ag_tcu_uop_seq;

  localparam logic [3:0] I32 = 4'd8, I8 = 4'd9, U8 = 4'd10, I4 = 4'd11, U4 = 4'd12;

  logic       clk, reset_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, err_fmt;
  logic [3:0] in_wid, in_fmt_s, in_fmt_d, out_wid, out_fmt_s, out_fmt_d;
  logic [7:0] in_tag, out_tag;
  logic [1:0] out_step_m, out_step_n, out_step_k;
  logic [5:0] out_rs1, out_rs2, out_rs3;
`ifdef AG_TCU_SEQ_PERF_EN
  logic [31:0] perf_wmma, perf_stall;
`endif

  ag_tcu_uop_seq #(.WID_W(4), .TAG_W(8), .REG_W(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_tag(in_tag),
    .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_tag(out_tag),
    .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d),
    .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_last(out_last), .err_fmt(err_fmt)
`ifdef AG_TCU_SEQ_PERF_EN
    , .perf_wmma(perf_wmma), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: each legal request becomes 64 expected uops, enumerated k-outer, m, n-inner.
  logic [44:0] exp_q[$];
  logic        err_exp  = 1'b0;
  logic [31:0] wmma_m   = '0;
  logic [31:0] stall_m  = '0;
  int          hs_total = 0;

  function automatic logic model_legal(input logic [3:0] fs, input logic [3:0] fd);
    return (fd == I32) && (fs >= I8) && (fs <= U4);
  endfunction

  task automatic push_request(input logic [3:0] wid, input logic [7:0] tag,
                              input logic [3:0] fs, input logic [3:0] fd);
    for (int k = 0; k < 4; k++)
      for (int m = 0; m < 4; m++)
        for (int n = 0; n < 4; n++) begin
          logic [5:0] r1, r2, r3;
          r1 = 6'(m * 4 + k);
          r2 = 6'(10 + (n * 4 + k) / 2);
          r3 = 6'(24 + m * 4 + n);
          exp_q.push_back({wid, tag, fs, fd, 2'(m), 2'(n), 2'(k), r1, r2, r3,
                           (k == 3 && m == 3 && n == 3)});
        end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      err_exp = 1'b0;
      wmma_m  = '0;
      stall_m = '0;
    end else begin
      logic busy, ir_exp;
      busy   = (exp_q.size() != 0);
      ir_exp = !busy || (out_ready && exp_q[0][0]);
      check("out_valid", out_valid, busy);
      check("in_ready", in_ready, ir_exp);
      check("err_fmt", err_fmt, err_exp);
      if (busy)
        check("uop", {out_wid, out_tag, out_fmt_s, out_fmt_d, out_step_m, out_step_n, out_step_k,
                      out_rs1, out_rs2, out_rs3, out_last}, exp_q[0]);
`ifdef AG_TCU_SEQ_PERF_EN
      check("perf_wmma", perf_wmma, wmma_m);
      check("perf_stall", perf_stall, stall_m);
`endif
      err_exp = 1'b0;
      if (busy && out_ready) begin
        void'(exp_q.pop_front());
        hs_total++;
      end else if (busy) begin
        stall_m++;
      end
      if (in_valid && ir_exp) begin
        if (model_legal(in_fmt_s, in_fmt_d)) begin
          push_request(in_wid, in_tag, in_fmt_s, in_fmt_d);
          wmma_m++;
        end else begin
          err_exp = 1'b1;
        end
      end
    end
  end

  int acc_cyc;

  // Present a request until accepted (bounded); returns 1 ns after the accepting edge.
  task automatic send_req(input logic [3:0] wid, input logic [7:0] tag,
                          input logic [3:0] fs, input logic [3:0] fd);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_wid = wid; in_tag = tag; in_fmt_s = fs; in_fmt_d = fd; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      n++;
    end
    check("req_accept", acc, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_a, hs0;
    logic [31:0] stall0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_wid = '0; in_tag = '0; in_fmt_s = '0; in_fmt_d = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_err_fmt", err_fmt, 1'b0);
    check("rst_fields", {out_wid, out_tag, out_fmt_s, out_fmt_d, out_step_m, out_step_n,
                         out_step_k, out_rs1, out_rs2, out_rs3, out_last}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: legal I8->I32, streaming at full rate
    send_req(4'd3, 8'hA5, I8, I32);
    @(negedge clk);
    check("t1_uop0_valid", out_valid, 1'b1);
    check("t1_uop0_step", {out_step_m, out_step_n, out_step_k}, 6'b00_00_00);
    check("t1_uop0_rs", {out_rs1, out_rs2, out_rs3}, {6'd0, 6'd10, 6'd24});
    @(negedge clk);
    check("t1_uop1_step", {out_step_m, out_step_n, out_step_k}, 6'b00_01_00);
    check("t1_uop1_rs", {out_rs1, out_rs2, out_rs3}, {6'd0, 6'd12, 6'd25});
    repeat (62) @(negedge clk);
    check("t1_uop63_step", {out_step_m, out_step_n, out_step_k}, 6'b11_11_11);
    check("t1_uop63_rs", {out_rs1, out_rs2, out_rs3}, {6'd15, 6'd17, 6'd39});
    check("t1_uop63_last", out_last, 1'b1);
    @(negedge clk);
    check("t1_idle_after", out_valid, 1'b0);
    @(posedge clk); #1;

    // 2: out_ready alternates 0/1, each uop stalls exactly once
    out_ready = 1'b0;
    send_req(4'd7, 8'h3C, U8, I32);
    hs0 = hs_total;
`ifdef AG_TCU_SEQ_PERF_EN
    stall0 = perf_stall;
`else
    stall0 = '0;
`endif
    for (int i = 0; i < 128; i++) begin
      out_ready = (i % 2 == 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("t2_uop_count", hs_total - hs0, 64);
`ifdef AG_TCU_SEQ_PERF_EN
    check("t2_perf_stall", perf_stall - stall0, 64);
`else
    check("t2_stall_base", stall0, 0);
`endif
    @(negedge clk);
    check("t2_idle_after", out_valid, 1'b0);
    @(posedge clk); #1;

    // 3: back-to-back, second request waits for the final handshake
    send_req(4'd1, 8'h11, I4, I32);
    t_a = acc_cyc;
    send_req(4'd2, 8'h22, U4, I32);
    check("t3_b2b_gap", acc_cyc - t_a, 64);
    @(negedge clk);
    check("t3_b_uop0_wid", {out_valid, out_wid}, {1'b1, 4'd2});
    repeat (66) @(posedge clk); #1;

    // 4: illegal destination format
    send_req(4'd4, 8'h44, I8, I8);
    @(negedge clk);
    check("t4_err_pulse", {err_fmt, out_valid}, 2'b10);
    @(negedge clk);
    check("t4_err_clear", {err_fmt, out_valid}, 2'b00);
    @(posedge clk); #1;

    // 5: async reset while uop 20 is presented
    send_req(4'd6, 8'h66, I8, I32);
    repeat (20) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    send_req(4'd5, 8'h55, U4, I32);
    @(negedge clk);
    check("t5_restart", {out_valid, out_wid, out_step_m, out_step_n, out_step_k,
                         out_rs1, out_rs2, out_rs3}, {1'b1, 4'd5, 6'd0, 6'd0, 6'd10, 6'd24});
    repeat (66) @(posedge clk); #1;

    // 6: illegal request accepted on the final handshake, then one more legal
    send_req(4'd8, 8'h88, I8, I32);
    send_req(4'd9, 8'h99, 4'd8, I32);
    @(negedge clk);
    check("t6_err_at_last", {err_fmt, out_valid}, 2'b10);
    @(posedge clk); #1;
    send_req(4'd10, 8'hAA, U8, I32);
    repeat (68) @(posedge clk); #1;
`ifdef AG_TCU_SEQ_PERF_EN
    check("t6_perf_wmma", perf_wmma, 32'd3);
`endif
    check("model_drained", exp_q.size(), 0);
    check("end_idle", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
